// File: rtl/mdu_iterative.sv
// mdu_iterative: bit-serial multiply/divide unit with HI/LO result registers and flush support
module mdu_iterative #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, sa, sb;
  logic [WIDTH-1:0] opnd;
  logic [2*WIDTH-1:0] acc;
  logic accept, sa_in, sb_in, dbz_in, ge;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0] msum, srem, diff;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod_s;
  logic [WIDTH-1:0] q_s, r_s;
  // operand capture, one shift-add / restoring-divide step, and sign fix-up
  always_comb begin
    accept = (state == IDLE || state == DONE) && start && !flush;
    sa_in  = SIGNED_EN && !op[0] && a[WIDTH-1];
    sb_in  = SIGNED_EN && !op[0] && b[WIDTH-1];
    a_mag  = sa_in ? -a : a;
    b_mag  = sb_in ? -b : b;
    dbz_in = op[1] && (b == '0);
    msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_nx = {msum, acc[WIDTH-1:1]};
    srem   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = srem - {1'b0, opnd};
    ge     = srem >= {1'b0, opnd};
    div_nx = {(ge ? diff[WIDTH-1:0] : srem[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    prod_s = (sa ^ sb) ? -acc : acc;
    q_s    = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_s    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // next-state logic; flush squashes CALC/FIX and blocks a same-cycle start
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (dbz_in ? DONE : CALC) : IDLE;
      CALC:    state_nx = flush ? IDLE : (cnt == '0 ? FIX : CALC);
      FIX:     state_nx = flush ? IDLE : DONE;
      default: state_nx = accept ? (dbz_in ? DONE : CALC) : IDLE;
    endcase
  end
  assign busy = (state == CALC) || (state == FIX);
  assign done = state == DONE;
  // state register, datapath iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        is_div      <= op[1];
        sa          <= sa_in;
        sb          <= sb_in;
        opnd        <= op[1] ? b_mag : a_mag;
        acc         <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        cnt         <= CW'(WIDTH - 1);
        div_by_zero <= dbz_in;
        if (dbz_in) begin
          hi <= a;
          lo <= '1;
        end
      end else if (state == CALC) begin
        acc <= is_div ? div_nx : mul_nx;
        cnt <= cnt - CW'(1);
      end else if (state == FIX && !flush) begin
        hi <= is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
        lo <= is_div ? q_s : prod_s[WIDTH-1:0];
      end
    end
  end
endmodule
